// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues one memory read at a time, presents the
// returned word to decode, and handles redirects (jumps) from any state.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        jump,
  input  logic [31:0] jump_addr,
  output logic [31:0] fetch_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    DRAIN
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] cnt_q, cnt_d;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; a jump always overrides pc and takes priority.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (jump) begin
          pc_d = jump_addr;
          // An accepted request with a stale address still owes a response.
          if (req_ready) state_d = DRAIN;
        end else if (req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (jump) begin
          pc_d    = jump_addr;
          state_d = rsp_valid ? REQ : DRAIN;
        end else if (rsp_valid) begin
          inst_d  = rsp_data;
          state_d = HOLD;
        end
      end
      DRAIN: begin
        if (jump) pc_d = jump_addr;
        if (rsp_valid) state_d = REQ;
      end
      HOLD: begin
        if (inst_ready) begin
          cnt_d   = cnt_q + 32'd1;
          pc_d    = jump ? jump_addr : pc_q + 32'd4;
          state_d = REQ;
        end else if (jump) begin
          pc_d    = jump_addr;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_valid  = (state_q == REQ);
  assign inst_valid = (state_q == HOLD);
  assign req_addr   = pc_q;
  assign inst_pc    = pc_q;
  assign inst       = inst_q;
  assign fetch_cnt  = cnt_q;

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter: RESET_PC, 32'h8000_0000, address of first fetch after reset.
REQ-002 clk  in  1  sole clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 req_valid  out  1  instruction-memory read request valid.
REQ-005 req_ready  in  1  memory accepts request; handshake when req_valid & req_ready.
REQ-006 req_addr  out  32  fetch address; equals internal pc.
REQ-007 rsp_valid  in  1  one-cycle pulse, read data valid; exactly one per accepted request, at least 1 cycle after acceptance.
REQ-008 rsp_data  in  32  instruction word, sampled only when rsp_valid=1.
REQ-009 inst_valid  out  1  instruction presented to decode.
REQ-010 inst_ready  in  1  decode consumes instruction; handshake when inst_valid & inst_ready.
REQ-011 inst  out  32  held instruction word.
REQ-012 inst_pc  out  32  address of held instruction (equals pc).
REQ-013 jump  in  1  redirect pulse from decode.
REQ-014 jump_addr  in  32  redirect target, sampled only when jump=1.
REQ-015 fetch_cnt  out  32  count of instructions consumed by decode.

Function
REQ-016 States SHALL be IDLE, REQ, WAIT, HOLD, DRAIN; req_valid=1 only in REQ; inst_valid=1 only in HOLD; all outputs registered or decoded from state only.
REQ-017 IDLE SHALL go to REQ on the next cycle unconditionally.
REQ-018 REQ, jump=0: req_ready=1 -> WAIT; req_ready=0 -> stay REQ; req_addr SHALL stay stable while stalled.
REQ-019 REQ, jump=1: pc<=jump_addr; req_ready=1 -> DRAIN (old request's response discarded); req_ready=0 -> stay REQ (req_addr changes only in this case).
REQ-020 WAIT, jump=0: rsp_valid=1 -> capture rsp_data into inst, go HOLD; else stay WAIT.
REQ-021 WAIT, jump=1: pc<=jump_addr; rsp_valid=1 same cycle -> discard data, go REQ; else go DRAIN.
REQ-022 DRAIN: rsp_valid=1 -> discard data, go REQ; jump=1 in DRAIN SHALL update pc<=jump_addr, state transition unchanged by jump.
REQ-023 HOLD, inst_ready=1: fetch_cnt<=fetch_cnt+1; pc<=jump ? jump_addr : pc+4; go REQ.
REQ-024 HOLD, inst_ready=0, jump=1: held instruction discarded, no count, pc<=jump_addr, go REQ.
REQ-025 HOLD, inst_ready=0, jump=0: inst, inst_pc stable, stay HOLD.
REQ-026 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000); fetch_cnt SHALL wrap modulo 2^32.
REQ-027 jump SHALL take priority over every non-reset event; latest jump_addr wins when multiple jumps occur before the next request issues.
REQ-028 At most one request SHALL be outstanding; req_valid SHALL be 0 in WAIT, DRAIN, HOLD.
REQ-029 Minimum fetch-to-decode latency: request accepted cycle N, rsp_valid at N+1, inst_valid at N+2.

Reset
REQ-030 While rst=1 (sampled at posedge): state<=IDLE, pc<=RESET_PC, inst<=0, fetch_cnt<=0; req_valid=0, inst_valid=0, inst_pc=RESET_PC.
REQ-031 Reset mid-operation (any state, including DRAIN/WAIT) SHALL override all inputs; a response arriving after reset release without a post-reset request SHALL be ignored (IDLE/REQ ignore rsp_valid).
REQ-032 First req_valid=1 SHALL occur in the 2nd cycle after rst deasserts, with req_addr=RESET_PC.

Verification
REQ-033 Straight line: req_ready=1, rsp 1 cycle later, inst_ready=1 -> req_addr 8000_0000, 8000_0004, 8000_0008; fetch_cnt=3 after third consume.
REQ-034 Backpressure: req_ready=0 for 4 cycles, then inst_ready=0 for 3 cycles -> req_addr, inst, inst_pc stable throughout; no second request issued.
REQ-035 Redirect in WAIT: request 8000_0004 accepted, jump=1 jump_addr=8000_0100, rsp 2 cycles later -> rsp discarded, inst_valid never shows it, next req_addr=8000_0100.
REQ-036 Jump+consume in HOLD: inst_pc=8000_0008, inst_ready=1, jump=1, jump_addr=8000_0040 -> fetch_cnt+1, next req_addr=8000_0040; jump without inst_ready -> no count.
REQ-037 Wrap: RESET_PC=FFFF_FFFC, consume one instruction -> next req_addr=0000_0000.
REQ-038 Reset in DRAIN: assert rst 1 cycle, stale rsp_valid pulse in following IDLE -> ignored; req_addr=RESET_PC, fetch_cnt=0.
